// File: rtl/argmax_classifier.sv
// argmax_classifier
// Last stage of the MNIST inference pipeline. Streams one logit vector per
// image, tracks the running maximum and runner-up, and emits a single result
// beat carrying the winning class, the winning logit and a saturated
// top-1/top-2 margin. A wrapping frame counter and a sticky framing-error
// flag are kept for scoreboard/debug visibility.
//
// state   | meaning
// --------+-----------------------------------------------------------
// COLLECT | accepting logit beats, in_ready=1, out_valid=0
// RESULT  | result beat presented, in_ready=0, out_valid=1
//
// The two states are mutually exclusive, so input and output acceptance can
// never happen on the same edge.

module argmax_classifier #(
    parameter int NUM_CLASSES   = 10,
    parameter int FEATURE_WIDTH = 16,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [FEATURE_WIDTH-1:0]       in_feature,
    input  logic                           in_last,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [$clog2(NUM_CLASSES)-1:0] out_class,
    output logic [FEATURE_WIDTH-1:0]       out_max,
    output logic [FEATURE_WIDTH-1:0]       out_margin,
    output logic [CNT_WIDTH-1:0]           frames_done,
    output logic                           frame_err
);

    localparam int IDX_W = $clog2(NUM_CLASSES);
    localparam int FW    = FEATURE_WIDTH;

    localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(NUM_CLASSES - 1);
    localparam logic signed [FW-1:0] MOST_NEG  = {1'b1, {(FW-1){1'b0}}};
    localparam logic [FW:0]          SAT_LIMIT = {2'b00, {(FW-1){1'b1}}};

    typedef enum logic {
        COLLECT = 1'b0,
        RESULT  = 1'b1
    } state_t;

    state_t                  state;
    logic [IDX_W-1:0]        beat_cnt;
    logic signed [FW-1:0]    cur_max;
    logic signed [FW-1:0]    cur_second;
    logic [IDX_W-1:0]        cur_idx;

    logic                    accept;
    logic                    at_last_idx;
    logic                    frame_end;
    logic                    err_now;
    logic signed [FW-1:0]    x;
    logic signed [FW-1:0]    nxt_max;
    logic signed [FW-1:0]    nxt_second;
    logic [IDX_W-1:0]        nxt_idx;
    logic [FW:0]             diff;
    logic [FW-1:0]           margin_sat;

    // Handshake flags are straight decodes of the state register, so there
    // is no combinational path from out_ready to in_ready.
    assign in_ready  = (state == COLLECT);
    assign out_valid = (state == RESULT);

    assign accept      = in_valid && in_ready;
    assign at_last_idx = (beat_cnt == LAST_IDX);
    assign frame_end   = accept && (in_last || at_last_idx);
    // An error is any disagreement between in_last and the beat position:
    // early last, or a full frame without last.
    assign err_now     = accept && (in_last != at_last_idx);
    assign x           = $signed(in_feature);

    // Running top-1/top-2 update for the beat currently being offered.
    // Strict '>' on the max keeps the lowest index on ties, while the
    // second-place compare lets a duplicate max land in second (margin 0).
    always_comb begin
        nxt_max    = cur_max;
        nxt_second = cur_second;
        nxt_idx    = cur_idx;
        if (beat_cnt == '0) begin
            nxt_max    = x;
            nxt_second = MOST_NEG;
            nxt_idx    = '0;
        end else if (x > cur_max) begin
            nxt_second = cur_max;
            nxt_max    = x;
            nxt_idx    = beat_cnt;
        end else if (x > cur_second) begin
            nxt_second = x;
        end
    end

    // Margin from the post-update values; one extra bit so max-second never
    // overflows, then clamp to the largest positive FW-bit value.
    always_comb begin
        diff = {nxt_max[FW-1], nxt_max} - {nxt_second[FW-1], nxt_second};
        if (diff > SAT_LIMIT) begin
            margin_sat = SAT_LIMIT[FW-1:0];
        end else begin
            margin_sat = diff[FW-1:0];
        end
    end

    // Controller: beat collection, result load/hold, frame counting and the
    // sticky framing-error flag. Reset drops any partial frame.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= COLLECT;
            beat_cnt    <= '0;
            cur_max     <= '0;
            cur_second  <= '0;
            cur_idx     <= '0;
            out_class   <= '0;
            out_max     <= '0;
            out_margin  <= '0;
            frames_done <= '0;
            frame_err   <= 1'b0;
        end else begin
            case (state)
                COLLECT: begin
                    if (accept) begin
                        cur_max    <= nxt_max;
                        cur_second <= nxt_second;
                        cur_idx    <= nxt_idx;
                        if (err_now) begin
                            frame_err <= 1'b1;
                        end
                        if (frame_end) begin
                            out_class  <= nxt_idx;
                            out_max    <= nxt_max;
                            out_margin <= margin_sat;
                            beat_cnt   <= '0;
                            state      <= RESULT;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                RESULT: begin
                    // Result registers are left untouched so they hold under
                    // backpressure and keep their values after acceptance.
                    if (out_ready) begin
                        frames_done <= frames_done + 1'b1;
                        state       <= COLLECT;
                    end
                end
                default: begin
                    state <= COLLECT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_argmax_classifier.sv
// Directed bench for argmax_classifier with hand-computed expectations.
module tb_argmax_classifier;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_feature = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  out_class;
    logic [15:0] out_max;
    logic [15:0] out_margin;
    logic [15:0] frames_done;
    logic        frame_err;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] vec [10];

    argmax_classifier #(
        .NUM_CLASSES  (10),
        .FEATURE_WIDTH(16),
        .CNT_WIDTH    (16)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_feature (in_feature),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_class  (out_class),
        .out_max    (out_max),
        .out_margin (out_margin),
        .frames_done(frames_done),
        .frame_err  (frame_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic send_beat(input logic [15:0] v, input logic last);
        int guard;
        guard = 0;
        in_valid   = 1'b1;
        in_feature = v;
        in_last    = last;
        while (!in_ready && guard < 200) begin
            @(negedge clock);
            guard++;
        end
        if (guard >= 200) chk("in_ready_timeout", 32'(in_ready), 32'd1);
        @(negedge clock);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Sends vec[0..n-1]; gap idle cycles with junk on the data lines between beats.
    task automatic send_vec(input int n, input bit with_last, input int gap);
        for (int i = 0; i < n; i++) begin
            send_beat(vec[i], with_last && (i == n - 1));
            if (i != n - 1) begin
                for (int g = 0; g < gap; g++) begin
                    in_feature = 16'h7fff;
                    in_last    = 1'b1;
                    @(negedge clock);
                end
                in_last = 1'b0;
            end
        end
    endtask

    // Result must be valid right now (one cycle after the last beat), then accept it.
    task automatic get_result(input string tag, input int e_cls, input logic [15:0] e_max,
                              input logic [15:0] e_mgn, input logic e_err, input int e_frames);
        chk({tag, "_valid"},  32'(out_valid),  32'd1);
        chk({tag, "_ready0"}, 32'(in_ready),   32'd0);
        chk({tag, "_class"},  32'(out_class),  32'(e_cls));
        chk({tag, "_max"},    32'(out_max),    32'(e_max));
        chk({tag, "_margin"}, 32'(out_margin), 32'(e_mgn));
        chk({tag, "_err"},    32'(frame_err),  32'(e_err));
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        chk({tag, "_valid_drop"}, 32'(out_valid),   32'd0);
        chk({tag, "_frames"},     32'(frames_done), 32'(e_frames));
    endtask

    initial begin
        // reset state
        repeat (2) @(negedge clock);
        chk("rst_ready",  32'(in_ready),    32'd1);
        chk("rst_valid",  32'(out_valid),   32'd0);
        chk("rst_class",  32'(out_class),   32'd0);
        chk("rst_max",    32'(out_max),     32'd0);
        chk("rst_margin", 32'(out_margin),  32'd0);
        chk("rst_frames", 32'(frames_done), 32'd0);
        chk("rst_err",    32'(frame_err),   32'd0);
        reset_n = 1'b1;
        @(negedge clock);

        // basic argmax, followed by 20 cycles of backpressure
        vec = '{16'd3, -16'sd5, 16'd12, 16'd7, 16'd0, 16'd1, -16'sd2, 16'd9, 16'd4, 16'd6};
        send_vec(10, 1'b1, 0);
        chk("basic_valid", 32'(out_valid),  32'd1);
        chk("basic_class", 32'(out_class),  32'd2);
        chk("basic_max",   32'(out_max),    32'd12);
        chk("basic_mgn",   32'(out_margin), 32'd3);
        chk("basic_err",   32'(frame_err),  32'd0);
        in_valid   = 1'b1;
        in_feature = 16'd0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            chk("bp_ready", 32'(in_ready),   32'd0);
            chk("bp_valid", 32'(out_valid),  32'd1);
            chk("bp_class", 32'(out_class),  32'd2);
            chk("bp_max",   32'(out_max),    32'd12);
            chk("bp_mgn",   32'(out_margin), 32'd3);
        end
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        chk("bp_accept_ready",  32'(in_ready),    32'd1);
        chk("bp_accept_valid",  32'(out_valid),   32'd0);
        chk("bp_accept_frames", 32'(frames_done), 32'd1);
        chk("bp_hold_after",    32'(out_class),   32'd2);

        // second frame 0..9 (beat 0 already on the bus)
        vec = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9};
        send_vec(10, 1'b1, 0);
        get_result("ramp", 9, 16'd9, 16'd1, 1'b0, 2);

        // ties and negatives, with bubbles carrying junk
        vec = '{-16'sd100, -16'sd100, -16'sd100, -16'sd100, -16'sd7,
                -16'sd100, -16'sd100, -16'sd100, -16'sd7, -16'sd100};
        send_vec(10, 1'b1, 2);
        get_result("tie", 4, -16'sd7, 16'd0, 1'b0, 3);

        // saturation of the margin
        vec = '{16'h7fff, 16'h8000, 16'h8000, 16'h8000, 16'h8000,
                16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000};
        send_vec(10, 1'b1, 0);
        get_result("sat", 0, 16'h7fff, 16'h7fff, 1'b0, 4);

        // early last on beat 5
        vec = '{16'd1, 16'd2, 16'd3, 16'd9, 16'd4, 16'd5, 16'd0, 16'd0, 16'd0, 16'd0};
        send_vec(6, 1'b1, 0);
        get_result("early", 3, 16'd9, 16'd4, 1'b1, 5);

        // missing last: frame still closes after 10 beats
        vec = '{16'd5, 16'd4, 16'd3, 16'd2, 16'd1, 16'd0, -16'sd1, -16'sd2, -16'sd3, -16'sd4};
        send_vec(10, 1'b0, 0);
        get_result("nolast", 0, 16'd5, 16'd1, 1'b1, 6);

        // single-beat frame saturates
        vec[0] = 16'd5;
        send_vec(1, 1'b1, 0);
        get_result("single", 0, 16'd5, 16'h7fff, 1'b1, 7);

        // reset mid-frame after beat 6
        vec = '{16'd20, 16'd30, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd0, 16'd0, 16'd0};
        for (int i = 0; i < 7; i++) send_beat(vec[i], 1'b0);
        reset_n = 1'b0;
        #1;
        chk("mrst_class",  32'(out_class),   32'd0);
        chk("mrst_max",    32'(out_max),     32'd0);
        chk("mrst_margin", 32'(out_margin),  32'd0);
        chk("mrst_frames", 32'(frames_done), 32'd0);
        chk("mrst_err",    32'(frame_err),   32'd0);
        chk("mrst_ready",  32'(in_ready),    32'd1);
        chk("mrst_valid",  32'(out_valid),   32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        vec = '{16'd4, 16'd8, -16'sd1, 16'd8, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd2};
        send_vec(10, 1'b1, 0);
        get_result("clean", 1, 16'd8, 16'd0, 1'b0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
